fifo_sync_flex: RTL
===================

# fifo_sync_flex

Single-clock, parametrised FIFO for the H.264 intra-frame datapath, where both producer and consumer run in the same clock domain. It takes the valid/ready FIFO interface of the dual-clock FIFO and adds: selectable first-word-fall-through (FWFT) or registered-read mode; programmable almost-full and almost-empty flags; an occupancy count; synchronous flush; and sticky overflow/underflow error flags. It buffers between pipeline stages such as the prediction, transform and CAVLC stages, and between the encoder and the RISC-V bus bridge.

## Interface
- DATA_WIDTH, 8, payload width in bits
- DEPTH, 16, number of entries; power of two, at least 2
- AFULL_THRESH, DEPTH-2, `wr_afull_o` asserts when count ≥ this value; range 1..DEPTH
- AEMPTY_THRESH, 1, `rd_aempty_o` asserts when count ≤ this value; range 0..DEPTH-1
- FWFT, 1, read mode: 1 = head word presented combinationally; 0 = word registered one cycle after the read request
- clk  in  1  single clock; all logic on the rising edge
- rst_n  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous clear of all contents
- wr_valid_i  in  1  write request
- wr_data_i  in  DATA_WIDTH  write payload
- wr_full_o  out  1  FIFO full; writes are ignored while high
- wr_afull_o  out  1  almost-full flag
- rd_ready_i  in  1  read request (FWFT=1: consumer accepts head; FWFT=0: request next word)
- rd_valid_o  out  1  `rd_data_o` is valid
- rd_data_o  out  DATA_WIDTH  read payload
- rd_empty_o  out  1  FIFO holds no entries
- rd_aempty_o  out  1  almost-empty flag
- count_o  out  $clog2(DEPTH)+1  number of stored entries, 0..DEPTH
- overflow_o  out  1  sticky: a write was attempted while full
- underflow_o  out  1  sticky: a read was attempted while empty

## Operation
- Storage: DEPTH × DATA_WIDTH register array.
- Pointers: write and read pointers of $clog2(DEPTH) bits each, wrapping modulo DEPTH.
- Count register: `count_o`, held separately from the pointers. Full is `count==DEPTH`; empty is `count==0`.
- Write accept: `wr_valid_i && !wr_full_o`. On accept, store at the write pointer and increment it.
- Pop condition:
  - FWFT=1: pop on `rd_valid_o && rd_ready_i`, where `rd_valid_o = !rd_empty_o` and `rd_data_o` = mem[rd_ptr] (combinational).
  - FWFT=0: pop on `rd_ready_i && !rd_empty_o`. `rd_data_o` is registered from mem[rd_ptr], and `rd_valid_o` pulses high for the one cycle after the pop. When no pop occurs, `rd_data_o` holds its last value.
- Count update: +1 on accept without pop, −1 on pop without accept, unchanged when both or neither occur.
- Simultaneous write and read:
  - When full, the write is rejected even if a pop occurs in the same cycle. The full decision uses the registered count; there is no same-cycle pass-through.
  - When empty, the write is accepted and the read is an underflow attempt.
  - There is no bypass. A word written while empty is first readable on the next cycle.
- Error flags:
  - `overflow_o` sets on `wr_valid_i && wr_full_o`.
  - `underflow_o` sets on `rd_ready_i && rd_empty_o`.
  - Both flags are cleared only by reset or flush.
- Flush:
  - Clears both pointers, the count, `rd_valid_o` and both sticky flags.
  - Takes priority over any write or read in the same cycle; that write is dropped.
  - Memory contents are not cleared.
- Almost flags are decoded from the registered count: `wr_afull_o = count ≥ AFULL_THRESH`, `rd_aempty_o = count ≤ AEMPTY_THRESH`.

## Timing
- Reset values (asynchronous, immediate on `rst_n` low):
  - count 0
  - `rd_empty_o`=1, `rd_aempty_o`=1, `wr_full_o`=0, `wr_afull_o`=0
  - `rd_valid_o`=0, `rd_data_o`=0
  - `overflow_o`=0, `underflow_o`=0
  - pointers 0
- Reset release is synchronous in effect: the first write can be accepted on the first rising edge with `rst_n` high.
- Latency, write to readable:
  - FWFT=1: 1 cycle. `rd_valid_o` is high in the cycle after the accepting edge.
  - FWFT=0: 1 cycle to non-empty, plus 1 cycle from pop to data.
- Flags (full, empty, afull, aempty, count) update on the same edge as the accept or pop that changes the count.
- Throughput: one write and one pop per cycle, sustained, when neither full nor empty.
- Reset asserted mid-burst: all state clears immediately; no partial word appears on the outputs.

## Test plan
- DEPTH=8, FWFT=1. Reset, then write 0x11..0x18 on consecutive cycles with `rd_ready_i`=0 → `count_o` 1..8; `wr_afull_o` high from count 6; `wr_full_o` high after the 8th write; a 9th write of 0x99 sets `overflow_o` and count stays 8.
- Drain the full FIFO with `rd_ready_i`=1 → `rd_data_o` is 0x11..0x18 in order, one per cycle; `rd_aempty_o` high at count ≤1; `rd_empty_o` high after the 8th pop; one extra read sets `underflow_o`.
- FWFT=0, write 0xA5 then assert `rd_ready_i` for one cycle → `rd_valid_o` pulses exactly one cycle later with `rd_data_o`=0xA5; `rd_data_o` then holds 0xA5.
- Wrap and simultaneous access: fill to count 4, then run 40 cycles with random `wr_valid_i`/`rd_ready_i` against a scoreboard queue → no data mismatch; count never leaves 0..8; pointers wrap at least 4 times; when full, a same-cycle write+read leaves count 7 and the write is rejected.
- Flush: count 5 with `overflow_o` set; assert `flush_i` together with `wr_valid_i` → next cycle count 0, `rd_empty_o`=1, `overflow_o`=0; the flushed-cycle write is not stored.
- Reset mid-operation: drop `rst_n` while count is 3 and `rd_valid_o` is high → all outputs reach their reset values without waiting for a clock edge; after release, write 0x3C and it is read back as the first word.

Source files
------------

// File: rtl/fifo_sync_flex.sv
// Single-clock FIFO with FWFT/registered read, almost flags,
// occupancy count, flush and sticky error flags.
module fifo_sync_flex #(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 16,
  parameter int AFULL_THRESH  = DEPTH - 2,
  parameter int AEMPTY_THRESH = 1,
  parameter int FWFT          = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush_i,
  input  logic                       wr_valid_i,
  input  logic [DATA_WIDTH-1:0]      wr_data_i,
  output logic                       wr_full_o,
  output logic                       wr_afull_o,
  input  logic                       rd_ready_i,
  output logic                       rd_valid_o,
  output logic [DATA_WIDTH-1:0]      rd_data_o,
  output logic                       rd_empty_o,
  output logic                       rd_aempty_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       overflow_o,
  output logic                       underflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  full;
  logic                  empty;
  logic                  wr_acc;
  logic                  pop;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign wr_acc = wr_valid_i && !full && !flush_i;
  assign pop    = rd_ready_i && !empty && !flush_i;

  assign wr_full_o   = full;
  assign rd_empty_o  = empty;
  assign wr_afull_o  = (count >= CW'(AFULL_THRESH));
  assign rd_aempty_o = (count <= CW'(AEMPTY_THRESH));
  assign count_o     = count;

  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else if (flush_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({wr_acc, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (wr_valid_i && full)  overflow_o  <= 1'b1;
      if (rd_ready_i && empty) underflow_o <= 1'b1;
    end
  end

  if (FWFT != 0) begin : g_fwft
    // Gate stale memory so an empty FIFO always shows zero data.
    assign rd_valid_o = !empty;
    assign rd_data_o  = empty ? '0 : mem[rd_ptr];
  end else begin : g_reg
    logic                  vld_q;
    logic [DATA_WIDTH-1:0] dat_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        dat_q <= '0;
      end else if (flush_i) begin
        vld_q <= 1'b0;
      end else begin
        vld_q <= pop;
        if (pop) dat_q <= mem[rd_ptr];
      end
    end

    assign rd_valid_o = vld_q;
    assign rd_data_o  = dat_q;
  end

endmodule
